// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch-queue entry type for the instruction-fetch stage.
// Optional build macro used by fetch_unit: FETCH_PERF_CNT_EN (adds perf counters).
package fetch_pkg;

  localparam int FETCH_ADDR_W   = 16;
  localparam int FETCH_INST_W   = 16;
  localparam int FETCH_DEPTH    = 4;
  localparam int FETCH_RESET_PC = 0;
  localparam int FETCH_PC_STEP  = 1;
  localparam int PERF_CNT_W     = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries with flush; head is read
// directly from registered storage so it stays stable while not popped.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = FETCH_DEPTH,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-cycle ROM interface, prefetch queue, redirect.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_flushes counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = FETCH_ADDR_W,
  parameter int          INST_W   = FETCH_INST_W,
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter int unsigned RESET_PC = FETCH_RESET_PC,
  parameter int unsigned PC_STEP  = FETCH_PC_STEP
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ren,
  input  logic [INST_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_fetched,
  output logic [PERF_CNT_W-1:0] perf_flushes
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] issued_addr;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occupancy;
  logic              push;
  logic              pop;
  logic              issue;
  entry_t            head;
  entry_t            push_entry;

  // Decode stream: a transfer happens on a cycle with inst_valid & inst_ready;
  // while inst_valid is high and not accepted, inst_data/inst_pc hold steady.
  // A redirect cycle never transfers.
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready & ~redirect_valid;
  assign push       = inflight & ~redirect_valid;

  // Credit check counts the in-flight response so every issued read has a slot.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = ~reset & fetch_en &
                     (redirect_valid | (occupancy < OCC_W'(DEPTH)));

  assign rom_addr = redirect_valid ? redirect_pc : pc;
  assign rom_ren  = issue;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      issued_addr <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= rom_addr + ADDR_W'(PC_STEP);
        issued_addr <= rom_addr;
      end else if (redirect_valid) begin
        pc <= redirect_pc;
      end
    end
  end

  assign push_entry = '{pc: issued_addr, inst: rom_data};

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign inst_data = head.inst;
  assign inst_pc   = head.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (push)           perf_fetched <= perf_fetched + 1'b1;
      if (redirect_valid) perf_flushes <= perf_flushes + 1'b1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule
